// File: rtl/updown_sweep_controller.sv
// Sweep controller for an external 4-bit up/down counter: ramps it between captured
// bounds with a programmable dwell at each end, for a set number of sweeps or until Stop.
module updown_sweep_controller #(
  parameter int DATA_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic [DATA_W-1:0] Q_in,
  input  logic [DATA_W-1:0] Upper,
  input  logic [DATA_W-1:0] Lower,
  input  logic [DATA_W-1:0] Dwell,
  input  logic [DATA_W-1:0] Cycles,
  output logic              Enable,
  output logic              up_down,
  output logic              Sweep_done,
  output logic              Cfg_error,
  output logic [DATA_W-1:0] Sweep_count,
  output logic [2:0]        State
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    HOLD_TOP = 3'd2,
    DOWN     = 3'd3,
    HOLD_BOT = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] upper_q, lower_q, dwell_q, cycles_q;
  logic [DATA_W-1:0] sweep_cnt_q, dwell_cnt_q;
  logic [DATA_W-1:0] sweep_cnt_inc;
  logic              cfg_err_q;
  logic              capture, cfg_reject, dwell_end, sweep_end;

  always_comb begin
    state_d       = state_q;
    capture       = 1'b0;
    cfg_reject    = 1'b0;
    sweep_cnt_inc = sweep_cnt_q + 1'b1;
    dwell_end     = (dwell_cnt_q == dwell_q);
    sweep_end     = (cycles_q != '0) && (sweep_cnt_inc == cycles_q);
    if (Stop && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Stop) begin
            if (Lower < Upper) begin
              capture = 1'b1;
              state_d = UP;
            end else begin
              cfg_reject = 1'b1;
            end
          end
        end
        UP:       if (Q_in >= upper_q) state_d = HOLD_TOP;
        HOLD_TOP: if (dwell_end) state_d = DOWN;
        DOWN:     if (Q_in <= lower_q) state_d = HOLD_BOT;
        HOLD_BOT: if (dwell_end) state_d = sweep_end ? DONE : UP;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Counter controls are suppressed while Reset or Stop is pending so an abort never moves the counter.
  always_comb begin
    Enable = 1'b0;
    case (state_q)
      UP:      Enable = (Q_in < upper_q);
      DOWN:    Enable = (Q_in > lower_q);
      default: Enable = 1'b0;
    endcase
    if (Reset || Stop) Enable = 1'b0;
    up_down     = Reset || !((state_q == DOWN) || (state_q == HOLD_BOT));
    Sweep_done  = (state_q == DONE) && !Reset && !Stop;
    Cfg_error   = cfg_err_q;
    Sweep_count = sweep_cnt_q;
    State       = state_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      upper_q     <= '0;
      lower_q     <= '0;
      dwell_q     <= '0;
      cycles_q    <= '0;
      sweep_cnt_q <= '0;
      dwell_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        upper_q     <= Upper;
        lower_q     <= Lower;
        dwell_q     <= Dwell;
        cycles_q    <= Cycles;
        sweep_cnt_q <= '0;
        cfg_err_q   <= 1'b0;
      end
      if (cfg_reject) cfg_err_q <= 1'b1;
      // Dwell counter restarts on every state change, so each hold begins at zero.
      if (state_d != state_q) begin
        dwell_cnt_q <= '0;
      end else if (state_q == HOLD_TOP || state_q == HOLD_BOT) begin
        dwell_cnt_q <= dwell_cnt_q + 1'b1;
      end
      if (state_q == HOLD_BOT && state_d != HOLD_BOT && state_d != IDLE) begin
        sweep_cnt_q <= sweep_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Bench for updown_sweep_controller: drives an up/down counter model and compares every
// cycle against an expected trace generated from the sweep rules.
module tb_updown_sweep_controller;

  logic       Clock = 1'b0;
  logic       Reset, Start, Stop;
  logic [3:0] Q_in, Upper, Lower, Dwell, Cycles;
  logic       Enable, up_down, Sweep_done, Cfg_error;
  logic [3:0] Sweep_count;
  logic [2:0] State;
  logic       load;
  logic [3:0] load_val;

  int n_err = 0;
  int n_checks = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       ud;
    logic       dn;
    logic [3:0] cnt;
    logic [3:0] q;
  } exp_t;

  exp_t trace[$];

  updown_sweep_controller #(.DATA_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
    .Q_in(Q_in), .Upper(Upper), .Lower(Lower), .Dwell(Dwell), .Cycles(Cycles),
    .Enable(Enable), .up_down(up_down), .Sweep_done(Sweep_done), .Cfg_error(Cfg_error),
    .Sweep_count(Sweep_count), .State(State)
  );

  always #5 Clock = ~Clock;

  // Downstream 4-bit up/down counter, with a bench-only preload.
  always @(posedge Clock) begin
    if (Reset)       Q_in <= 4'd0;
    else if (load)   Q_in <= load_val;
    else if (Enable) Q_in <= up_down ? Q_in + 4'd1 : Q_in - 4'd1;
  end

  function automatic logic [15:0] pk(logic [2:0] st, logic en, logic ud, logic dn, logic cfg,
                                     logic [3:0] cnt, logic [3:0] q);
    return {1'b0, st, en, ud, dn, cfg, cnt, q};
  endfunction

  function automatic logic [15:0] obs();
    return pk(State, Enable, up_down, Sweep_done, Cfg_error, Sweep_count, Q_in);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int st, input int en, input int ud, input int dn, input int cnt, input int q);
    exp_t e;
    e.st  = 3'(st);
    e.en  = en[0];
    e.ud  = ud[0];
    e.dn  = dn[0];
    e.cnt = 4'(cnt);
    e.q   = 4'(q);
    trace.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of a run, starting on the cycle after the Start edge.
  task automatic build(input int up, input int lo, input int dw, input int cyc, input int q0, input int nsw);
    int q, cnt;
    trace.delete();
    q = q0;
    cnt = 0;
    for (int s = 0; s < nsw; s++) begin
      while (q < up) begin push(1, 1, 1, 0, cnt, q); q++; end
      push(1, 0, 1, 0, cnt, q);
      repeat (dw + 1) push(2, 0, 1, 0, cnt, q);
      while (q > lo) begin push(3, 1, 0, 0, cnt, q); q--; end
      push(3, 0, 0, 0, cnt, q);
      repeat (dw + 1) push(4, 0, 0, 0, cnt, q);
      cnt = (cnt + 1) % 16;
      if (cyc != 0 && cnt == cyc) begin
        push(5, 0, 1, 1, cnt, q);
        push(0, 0, 1, 0, cnt, q);
        return;
      end
    end
  endtask

  function automatic int find_idx(input int st, input int q);
    for (int i = 0; i < trace.size(); i++)
      if (int'(trace[i].st) == st && (q < 0 || int'(trace[i].q) == q)) return i;
    return -1;
  endfunction

  // kind: 0 = run to completion, 1 = Stop at abort_at, 2 = Reset at abort_at
  task automatic run(input string tag, input int up, input int lo, input int dw, input int cyc,
                     input int q0, input int abort_at, input int kind);
    exp_t e;
    load = 1'b1;
    load_val = 4'(q0);
    @(negedge Clock);
    load = 1'b0;
    Upper = 4'(up); Lower = 4'(lo); Dwell = 4'(dw); Cycles = 4'(cyc);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Upper = 4'($urandom); Lower = 4'($urandom); Dwell = 4'($urandom); Cycles = 4'($urandom);
    for (int i = 0; i < trace.size(); i++) begin
      e = trace[i];
      if (i == abort_at) begin
        if (kind == 1) Stop = 1'b1; else Reset = 1'b1;
        #1;
        chk({tag, "_abort"}, obs(), pk(e.st, 1'b0, (kind == 2) ? 1'b1 : e.ud, 1'b0, 1'b0, e.cnt, e.q));
        @(negedge Clock);
        if (kind == 1) chk({tag, "_stopped"}, obs(), pk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, e.cnt, e.q));
        else           chk({tag, "_reset"}, obs(), pk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0));
        Stop = 1'b0;
        Reset = 1'b0;
        return;
      end
      chk(tag, obs(), pk(e.st, e.en, e.ud, e.dn, 1'b0, e.cnt, e.q));
      @(negedge Clock);
    end
  endtask

  task automatic illegal_start(input string tag, input int up, input int lo);
    Upper = 4'(up); Lower = 4'(lo);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk(tag, {11'd0, State, Enable, Cfg_error}, {11'd0, 3'd0, 1'b0, 1'b1});
    @(negedge Clock);
    chk({tag, "_hold"}, {11'd0, State, Enable, Cfg_error}, {11'd0, 3'd0, 1'b0, 1'b1});
  endtask

  initial begin
    int idx;
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; load = 1'b0; load_val = 4'd0;
    Upper = 4'd0; Lower = 4'd0; Dwell = 4'd0; Cycles = 4'd0;
    @(negedge Clock);
    Start = 1'b1;
    Stop = 1'b1;
    @(negedge Clock);
    #1;
    chk("in_reset", obs(), pk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0));
    @(negedge Clock);
    Reset = 1'b0; Start = 1'b0; Stop = 1'b0;
    @(negedge Clock);
    chk("after_reset", obs(), pk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0));

    illegal_start("cfg_equal", 7, 7);

    build(5, 2, 1, 1, 0, 1);
    run("basic", 5, 2, 1, 1, 0, -1, 0);

    build(15, 0, 0, 0, 0, 20);
    run("freerun", 15, 0, 0, 0, 0, trace.size() - 1, 1);

    build(9, 1, 0, 2, 0, 2);
    idx = find_idx(3, 4);
    run("stop_down4", 9, 1, 0, 2, 0, idx, 1);

    build(8, 3, 2, 1, 0, 1);
    idx = find_idx(2, -1);
    run("reset_hold", 8, 3, 2, 1, 0, idx, 2);

    build(6, 1, 0, 1, 12, 1);
    run("above_top", 6, 1, 0, 1, 12, -1, 0);

    for (int r = 0; r < 25; r++) begin
      int up, lo, dw, cyc, q0, nsw, ab, kind, sel;
      up  = int'($urandom_range(15, 1));
      lo  = int'($urandom_range(up - 1, 0));
      dw  = int'($urandom_range(3, 0));
      cyc = int'($urandom_range(3, 0));
      q0  = int'($urandom_range(15, 0));
      nsw = (cyc == 0) ? int'($urandom_range(3, 1)) : cyc;
      build(up, lo, dw, cyc, q0, nsw);
      ab = -1;
      kind = 0;
      if (cyc == 0) begin
        ab = trace.size() - 1;
        kind = 1;
      end else begin
        sel = int'($urandom_range(5, 0));
        if (sel < 3) begin
          kind = (sel == 2) ? 2 : 1;
          ab = int'($urandom_range(trace.size() - 2, 0));
        end
      end
      run("rand", up, lo, dw, cyc, q0, ab, kind);
      if (r % 5 == 0) begin
        lo = int'($urandom_range(15, 0));
        up = int'($urandom_range(lo, 0));
        illegal_start("cfg_rand", up, lo);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/updown_sweep_controller.md
UPDOWN_SWEEP_CONTROLLER -- requirements
Module: updown_sweep_controller

Interface
REQ-001 SHALL have port: Clock  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clock.
REQ-003 SHALL have port: Start  input  1  level; sampled in IDLE to begin a sweep run.
REQ-004 SHALL have port: Stop  input  1  level; aborts any active run.
REQ-005 SHALL have port: Q_in  input  4  current value of the downstream up/down counter.
REQ-006 SHALL have port: Upper  input  4  sweep top bound.
REQ-007 SHALL have port: Lower  input  4  sweep bottom bound.
REQ-008 SHALL have port: Dwell  input  4  extra hold cycles at each bound.
REQ-009 SHALL have port: Cycles  input  4  number of full sweeps; 0 means run until Stop.
REQ-010 SHALL have port: Enable  output  1  count enable to the counter.
REQ-011 SHALL have port: up_down  output  1  direction to the counter; 1 = up, 0 = down.
REQ-012 SHALL have port: Sweep_done  output  1  one-cycle pulse at the end of a run.
REQ-013 SHALL have port: Cfg_error  output  1  sticky flag for an illegal configuration.
REQ-014 SHALL have port: Sweep_count  output  4  completed sweeps in the current run.
REQ-015 SHALL have port: State  output  3  current FSM state code.

Function
REQ-016 SHALL implement the states IDLE=0, UP=1, HOLD_TOP=2, DOWN=3, HOLD_BOT=4, DONE=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-017 In IDLE with Start=1 and Lower<Upper, SHALL capture Upper, Lower, Dwell and Cycles into internal registers, clear Sweep_count, clear Cfg_error, and enter UP on that edge.
REQ-018 In IDLE with Start=1 and Lower>=Upper, SHALL set Cfg_error=1 and remain in IDLE.
REQ-019 Configuration inputs SHALL be ignored outside the capture edge; the FSM uses only the captured values.
REQ-020 Enable SHALL be combinational from the state register, the captured bounds and Q_in, and SHALL be latch-free:
  - UP: Enable = (Q_in < Upper)
  - DOWN: Enable = (Q_in > Lower)
  - all other states: Enable = 0
REQ-021 up_down SHALL be 0 in DOWN and HOLD_BOT, and 1 in all other states.
REQ-022 UP SHALL go to HOLD_TOP on the edge where Q_in >= Upper; the counter never wraps and never overshoots the bound.
REQ-023 DOWN SHALL go to HOLD_BOT on the edge where Q_in <= Lower.
REQ-024 HOLD_TOP and HOLD_BOT SHALL last Dwell+1 cycles, timed by an internal 4-bit dwell counter that loads 0 on entry.
  - HOLD_TOP SHALL then go to DOWN.
  - HOLD_BOT SHALL then increment Sweep_count.
REQ-025 On leaving HOLD_BOT:
  - if Cycles!=0 and the incremented Sweep_count equals Cycles, SHALL go to DONE;
  - otherwise SHALL go to UP.
REQ-026 Sweep_count SHALL wrap from 15 to 0 when Cycles=0.
REQ-027 DONE SHALL last exactly one cycle with Sweep_done=1, then go to IDLE; Sweep_done SHALL be 0 in all other states.
REQ-028 Stop=1 in any state other than IDLE SHALL force IDLE on the next edge without asserting Sweep_done, and SHALL keep Sweep_count.
REQ-029 Stop SHALL have priority over Start and over all normal transitions.
REQ-030 If the counter starts above Upper, UP SHALL exit to HOLD_TOP immediately (Enable=0 that cycle) and DOWN SHALL then bring the counter down normally.

Reset
REQ-031 Reset=1 at a rising Clock edge SHALL set State=IDLE, Sweep_count=0, Cfg_error=0, the dwell counter to 0 and the captured registers to 0.
REQ-032 While in reset, the outputs SHALL be Enable=0, up_down=1, Sweep_done=0.
REQ-033 Reset SHALL override Stop and Start, and SHALL take effect mid-run in any state.

Verification
REQ-034 Bench SHALL connect the DUT to a 4-bit up/down counter model (Clock, Reset, Enable, up_down) with a 10 ns clock.
REQ-035 Scenario: counter at 0, Lower=2, Upper=5, Dwell=1, Cycles=1, Start pulse -> required response:
  - Q_in goes 0 to 5 over 5 enabled cycles;
  - HOLD_TOP lasts 2 cycles;
  - Q_in goes 5 to 2 over 3 cycles;
  - HOLD_BOT lasts 2 cycles;
  - Sweep_done pulses once, Sweep_count=1, State=0.
REQ-036 Scenario: Lower=7, Upper=7, Start -> Cfg_error=1, State stays 0, Enable stays 0; a following legal Start clears Cfg_error.
REQ-037 Scenario: Cycles=0, Lower=0, Upper=15, Dwell=0 for 20 sweeps -> Q_in never wraps, Sweep_count wraps from 15 to 0, no Sweep_done.
REQ-038 Scenario: Stop asserted in DOWN at Q_in=4 -> State=0 on the next edge, Enable=0, Q_in holds 4, Sweep_done stays 0.
REQ-039 Scenario: Reset asserted in HOLD_TOP -> on the next edge State=0, Sweep_count=0, Enable=0, up_down=1.
REQ-040 Scenario: counter preloaded at 12, Lower=1, Upper=6, Start -> UP exits with no count; Q_in descends 12 to 1 in DOWN with no wrap.
